// File: rtl/volatility_pkg.sv
// Shared types, widths and address helpers for the volatility read controller.
// The widths below follow the buffer geometry; stock_base maps a stock to its region.
package volatility_pkg;

  localparam int NUM_STOCKS  = 4;
  localparam int BUFFER_SIZE = 20;
  localparam int DATA_WIDTH  = 32;

  localparam int ID_W   = $clog2(NUM_STOCKS);
  localparam int ADDR_W = $clog2(NUM_STOCKS * BUFFER_SIZE);
  localparam int CNT_W  = $clog2(BUFFER_SIZE + 1);
  localparam int IDX_W  = $clog2(BUFFER_SIZE);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2
  } state_e;

  function automatic logic [ADDR_W-1:0] stock_base(input logic [ID_W-1:0] id);
    return ADDR_W'(id) * ADDR_W'(BUFFER_SIZE);
  endfunction

  // Advance a ring index, wrapping at the active window length.
  function automatic logic [IDX_W-1:0] idx_step(input logic [IDX_W-1:0]      idx,
                                                input logic [DATA_WIDTH-1:0] bsz);
    if (DATA_WIDTH'(idx) == (bsz - DATA_WIDTH'(1))) begin
      return '0;
    end
    return idx + IDX_W'(1);
  endfunction

endpackage

// File: rtl/volatility_ptr_tracker.sv
// Mirror of the write controller's per-stock write pointer and fill count.
// The lookup port reads registered state, so it never sees a same-cycle write.
module volatility_ptr_tracker
  import volatility_pkg::*;
(
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [DATA_WIDTH-1:0] buf_size_i,
  input  logic                  wr_valid_i,
  input  logic [ID_W-1:0]       wr_id_i,
  output logic                  wr_full_o,
  input  logic [ID_W-1:0]       lk_id_i,
  output logic [CNT_W-1:0]      lk_count_o,
  output logic [IDX_W-1:0]      lk_oldest_o
);

  logic [IDX_W-1:0] ptr_q [NUM_STOCKS];
  logic [CNT_W-1:0] cnt_q [NUM_STOCKS];
  logic [IDX_W-1:0] ptr_d;
  logic [CNT_W-1:0] cnt_d;
  logic             wr_sat;

  assign wr_sat    = (DATA_WIDTH'(cnt_q[wr_id_i]) >= buf_size_i);
  assign wr_full_o = wr_valid_i && wr_sat;
  assign ptr_d     = idx_step(ptr_q[wr_id_i], buf_size_i);
  assign cnt_d     = wr_sat ? cnt_q[wr_id_i] : cnt_q[wr_id_i] + CNT_W'(1);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int s = 0; s < NUM_STOCKS; s++) begin
        ptr_q[s] <= '0;
        cnt_q[s] <= '0;
      end
    end else if (wr_valid_i) begin
      ptr_q[wr_id_i] <= ptr_d;
      cnt_q[wr_id_i] <= cnt_d;
    end
  end

  // Until the window fills, the oldest entry sits at index 0.
  assign lk_count_o  = cnt_q[lk_id_i];
  assign lk_oldest_o = (DATA_WIDTH'(cnt_q[lk_id_i]) < buf_size_i) ? '0 : ptr_q[lk_id_i];

endmodule

// File: rtl/volatility_rd_ctrl.sv
// Read-side controller: bursts one stock's stored window, oldest to newest,
// out of a synchronous-read RAM toward the volatility compute stage.
module volatility_rd_ctrl
  import volatility_pkg::*;
(
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_wr_valid,
  input  logic [ID_W-1:0]       i_wr_stock_id,
  input  logic [DATA_WIDTH-1:0] i_buffer_size,
  input  logic                  i_rd_req,
  input  logic [ID_W-1:0]       i_rd_stock_id,
  output logic                  o_rd_en,
  output logic [ADDR_W-1:0]     o_rd_addr,
  input  logic [DATA_WIDTH-1:0] i_rd_data,
  output logic [DATA_WIDTH-1:0] o_sample,
  output logic                  o_sample_valid,
  output logic                  o_sample_last,
  output logic                  o_empty_done,
  output logic                  o_overrun,
  output logic                  o_busy
);

  state_e            state_q;
  logic [ID_W-1:0]   rd_id_q;
  logic [IDX_W-1:0]  idx_q;
  logic [CNT_W-1:0]  remain_q;
  logic              rd_en_q;
  logic [ADDR_W-1:0] rd_addr_q;
  logic              vld_q;
  logic              last_q;
  logic              ovr_q;
  logic              ovr_sticky_q;
  logic              empty_q;

  logic [CNT_W-1:0]  lk_count;
  logic [IDX_W-1:0]  lk_oldest;
  logic              wr_full;
  logic              ovr_hit;

  volatility_ptr_tracker u_tracker (
    .clk_i       (i_clk),
    .rst_i       (i_reset),
    .buf_size_i  (i_buffer_size),
    .wr_valid_i  (i_wr_valid),
    .wr_id_i     (i_wr_stock_id),
    .wr_full_o   (wr_full),
    .lk_id_i     (i_rd_stock_id),
    .lk_count_o  (lk_count),
    .lk_oldest_o (lk_oldest)
  );

  assign ovr_hit = wr_full && (i_wr_stock_id == rd_id_q);

  // Overrun is sampled over the address-issue cycles; it rides out with the last sample.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q      <= IDLE;
      rd_id_q      <= '0;
      idx_q        <= '0;
      remain_q     <= '0;
      rd_en_q      <= 1'b0;
      rd_addr_q    <= '0;
      vld_q        <= 1'b0;
      last_q       <= 1'b0;
      ovr_q        <= 1'b0;
      ovr_sticky_q <= 1'b0;
      empty_q      <= 1'b0;
    end else begin
      vld_q   <= rd_en_q;
      empty_q <= 1'b0;
      last_q  <= 1'b0;
      ovr_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          rd_en_q      <= 1'b0;
          rd_addr_q    <= '0;
          ovr_sticky_q <= 1'b0;
          if (i_rd_req) begin
            if (lk_count == '0) begin
              empty_q <= 1'b1;
            end else begin
              state_q   <= READ;
              rd_id_q   <= i_rd_stock_id;
              rd_en_q   <= 1'b1;
              rd_addr_q <= stock_base(i_rd_stock_id) + ADDR_W'(lk_oldest);
              idx_q     <= idx_step(lk_oldest, i_buffer_size);
              remain_q  <= lk_count - CNT_W'(1);
            end
          end
        end
        READ: begin
          if (remain_q == '0) begin
            state_q      <= DRAIN;
            rd_en_q      <= 1'b0;
            rd_addr_q    <= '0;
            last_q       <= 1'b1;
            ovr_q        <= ovr_sticky_q || ovr_hit;
            ovr_sticky_q <= 1'b0;
          end else begin
            rd_addr_q    <= stock_base(rd_id_q) + ADDR_W'(idx_q);
            idx_q        <= idx_step(idx_q, i_buffer_size);
            remain_q     <= remain_q - CNT_W'(1);
            ovr_sticky_q <= ovr_sticky_q || ovr_hit;
          end
        end
        DRAIN: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign o_rd_en        = rd_en_q;
  assign o_rd_addr      = rd_addr_q;
  assign o_sample       = vld_q ? i_rd_data : '0;
  assign o_sample_valid = vld_q;
  assign o_sample_last  = last_q;
  assign o_empty_done   = empty_q;
  assign o_overrun      = ovr_q;
  assign o_busy         = (state_q != IDLE);

endmodule

// File: tb/tb_volatility_rd_ctrl.sv
// Scoreboard bench for volatility_rd_ctrl: directed scenarios plus random traffic
// checked against a window-level reference model of the sample buffer.
module tb_volatility_rd_ctrl;
  import volatility_pkg::*;

  logic                  clk = 1'b0;
  logic                  i_reset = 1'b1;
  logic                  i_wr_valid = 1'b0;
  logic [ID_W-1:0]       i_wr_stock_id = '0;
  logic [DATA_WIDTH-1:0] i_buffer_size = 32'd20;
  logic                  i_rd_req = 1'b0;
  logic [ID_W-1:0]       i_rd_stock_id = '0;
  logic                  o_rd_en;
  logic [ADDR_W-1:0]     o_rd_addr;
  logic [DATA_WIDTH-1:0] i_rd_data = '0;
  logic [DATA_WIDTH-1:0] o_sample;
  logic                  o_sample_valid, o_sample_last, o_empty_done, o_overrun, o_busy;

  volatility_rd_ctrl dut (
    .i_clk          (clk),
    .i_reset        (i_reset),
    .i_wr_valid     (i_wr_valid),
    .i_wr_stock_id  (i_wr_stock_id),
    .i_buffer_size  (i_buffer_size),
    .i_rd_req       (i_rd_req),
    .i_rd_stock_id  (i_rd_stock_id),
    .o_rd_en        (o_rd_en),
    .o_rd_addr      (o_rd_addr),
    .i_rd_data      (i_rd_data),
    .o_sample       (o_sample),
    .o_sample_valid (o_sample_valid),
    .o_sample_last  (o_sample_last),
    .o_empty_done   (o_empty_done),
    .o_overrun      (o_overrun),
    .o_busy         (o_busy)
  );

  always #5 clk = ~clk;

  logic [31:0] ram [0:NUM_STOCKS*BUFFER_SIZE-1];
  always @(posedge clk) if (o_rd_en) i_rd_data <= ram[o_rd_addr];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s got=%0d want=%0d at %0t", name, got, want, $time);
    end
  endtask

  typedef struct {logic [31:0] data; bit last; bit ovr; bit empty;} exp_t;
  typedef struct {bit busy; bit rden;} ctl_t;
  exp_t exp_q[$];
  ctl_t ctl_q[$];

  // Reference model: per-stock write position and fill level, plus the burst in flight.
  int m_ptr [NUM_STOCKS];
  int m_cnt [NUM_STOCKS];
  int bs = 20;
  bit act = 0;
  int rel, bn, bstock;
  bit bovr;
  logic [31:0] blast_data;

  task automatic model_clear();
    for (int s = 0; s < NUM_STOCKS; s++) begin
      m_ptr[s] = 0;
      m_cnt[s] = 0;
    end
    act = 0;
  endtask

  task automatic step(input bit wr, input int wid, input bit req, input int rid);
    exp_t e;
    ctl_t c;
    int n, old, a;
    @(posedge clk); #1;
    if (act) begin
      rel++;
      if (rel > bn + 1) act = 0;
    end
    i_wr_valid = wr;
    i_wr_stock_id = ID_W'(wid);
    i_rd_req = req;
    i_rd_stock_id = ID_W'(rid);
    if (act && rel <= bn && wr && wid == bstock && m_cnt[wid] == bs) bovr = 1;
    if (act && rel == bn) begin
      e = '{blast_data, 1'b1, bovr, 1'b0};
      exp_q.push_back(e);
    end
    c = '{act, act && rel <= bn};
    ctl_q.push_back(c);
    if (!act && req) begin
      n = m_cnt[rid];
      if (n == 0) begin
        e = '{32'd0, 1'b0, 1'b0, 1'b1};
        exp_q.push_back(e);
      end else begin
        old = (n < bs) ? 0 : m_ptr[rid];
        for (int k = 0; k < n; k++) begin
          a = rid * BUFFER_SIZE + (old + k) % bs;
          if (k < n - 1) begin
            e = '{ram[a], 1'b0, 1'b0, 1'b0};
            exp_q.push_back(e);
          end else begin
            blast_data = ram[a];
          end
        end
        act = 1; rel = 0; bn = n; bstock = rid; bovr = 0;
      end
    end
    if (wr) begin
      m_ptr[wid] = (m_ptr[wid] + 1) % bs;
      if (m_cnt[wid] < bs) m_cnt[wid]++;
    end
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) step(0, 0, 0, 0);
  endtask

  task automatic do_reset(input int new_bs);
    ctl_t c;
    @(posedge clk); #1;
    if (act) begin
      rel++;
      if (rel > bn + 1) act = 0;
    end
    i_reset = 1'b1;
    i_wr_valid = 1'b0;
    i_rd_req = 1'b0;
    i_buffer_size = new_bs;
    c = '{act, act && rel <= bn};
    ctl_q.push_back(c);
    @(posedge clk); #1;
    i_reset = 1'b0;
    exp_q.delete();
    model_clear();
    bs = new_bs;
    c = '{1'b0, 1'b0};
    ctl_q.push_back(c);
    @(negedge clk);
    chk("rst_rd_en", o_rd_en, 0);
    chk("rst_rd_addr", o_rd_addr, 0);
    chk("rst_sample", o_sample, 0);
    chk("rst_sample_valid", o_sample_valid, 0);
    chk("rst_last", o_sample_last, 0);
    chk("rst_empty_done", o_empty_done, 0);
    chk("rst_overrun", o_overrun, 0);
    chk("rst_busy", o_busy, 0);
  endtask

  ctl_t mc;
  exp_t me;
  always @(negedge clk) begin
    if (ctl_q.size() > 0) begin
      mc = ctl_q.pop_front();
      chk("busy", o_busy, mc.busy);
      chk("rd_en", o_rd_en, mc.rden);
    end
    if (o_sample_valid === 1'b1 || o_empty_done === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_output", {o_sample_valid, o_empty_done}, 0);
      end else begin
        me = exp_q.pop_front();
        if (me.empty) begin
          chk("empty_done", o_empty_done, 1);
          chk("empty_no_sample", o_sample_valid, 0);
        end else begin
          chk("sample", o_sample, me.data);
          chk("last", o_sample_last, me.last);
          chk("overrun", o_overrun, me.ovr);
          chk("sample_no_empty", o_empty_done, 0);
        end
      end
    end else begin
      chk("idle_last", o_sample_last, 0);
      chk("idle_overrun", o_overrun, 0);
    end
  end

  initial begin
    for (int i = 0; i < NUM_STOCKS * BUFFER_SIZE; i++) ram[i] = $urandom;
    ram[20] = 32'd100;
    ram[21] = 32'd101;
    ram[22] = 32'd102;
    model_clear();

    // Empty read straight after reset.
    do_reset(20);
    step(0, 0, 1, 2);
    idle(3);

    // Partial fill of stock 1.
    for (int i = 0; i < 3; i++) step(1, 1, 0, 0);
    step(0, 0, 1, 1);
    idle(6);

    // Wrapped window, then overrun with an ignored second request.
    do_reset(5);
    for (int i = 0; i < 7; i++) step(1, 0, 0, 0);
    step(0, 0, 1, 0);
    idle(8);
    step(0, 0, 1, 0);
    step(0, 0, 0, 0);
    step(1, 0, 1, 0);
    idle(6);
    step(0, 0, 1, 3);
    idle(3);

    // Write and request to the same stock in the same cycle.
    for (int i = 0; i < 4; i++) step(1, 3, 0, 0);
    step(1, 3, 1, 3);
    idle(7);
    step(0, 0, 1, 3);
    idle(8);

    // Reset in the middle of a 10-sample burst.
    do_reset(20);
    for (int i = 0; i < 10; i++) step(1, 1, 0, 0);
    step(0, 0, 1, 1);
    idle(2);
    do_reset(20);
    step(0, 0, 1, 1);
    idle(3);

    // Random traffic under three window lengths.
    for (int ph = 0; ph < 3; ph++) begin
      do_reset(ph == 0 ? 20 : (ph == 1 ? 5 : int'($urandom_range(1, 20))));
      for (int i = 0; i < 500; i++)
        step($urandom_range(0, 9) < 4, $urandom_range(0, 3), $urandom_range(0, 9) < 2,
             $urandom_range(0, 3));
    end

    idle(30);
    chk("queue_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/volatility_rd_ctrl.md
Name: volatility_rd_ctrl

Overview:
- Read-side controller for the per-stock circular sample buffer (NUM_STOCKS x BUFFER_SIZE entries).
- The write controller fills that buffer; this block mirrors its per-stock write pointer and fill count.
- On request, it bursts one stock's stored window out of the synchronous-read RAM, oldest to newest, to the volatility compute stage.

Parameters:
- NUM_STOCKS, 4, number of stocks; each owns one buffer region.
- BUFFER_SIZE, 20, maximum entries per stock region.
- DATA_WIDTH, 32, sample width and i_buffer_size width.

Ports:
- i_clk  in  1  clock, all logic on rising edge.
- i_reset  in  1  synchronous reset, active-high.
- i_wr_valid  in  1  write event, same strobe the write controller consumes.
- i_wr_stock_id  in  $clog2(NUM_STOCKS)  stock of the write event.
- i_buffer_size  in  DATA_WIDTH  active window length, 1..BUFFER_SIZE; static between resets.
- i_rd_req  in  1  burst request, single-cycle pulse; sampled only in IDLE.
- i_rd_stock_id  in  $clog2(NUM_STOCKS)  stock to read; valid with i_rd_req.
- o_rd_en  out  1  RAM read enable.
- o_rd_addr  out  $clog2(NUM_STOCKS*BUFFER_SIZE)  RAM read address.
- i_rd_data  in  DATA_WIDTH  RAM data; valid the cycle after o_rd_en.
- o_sample  out  DATA_WIDTH  combinational pass-through of i_rd_data.
- o_sample_valid  out  1  o_sample is valid.
- o_sample_last  out  1  final sample of the burst.
- o_empty_done  out  1  one-cycle pulse when the requested stock holds 0 samples.
- o_overrun  out  1  qualifies the last sample: a same-stock write hit a full window during the burst.
- o_busy  out  1  high in READ and DRAIN.

Behaviour:

Reset:
- All per-stock ptr and count cleared to 0.
- State goes to IDLE.
- All outputs are 0.
- Reset mid-burst aborts immediately; no o_sample_last is emitted.

Write tracking (every cycle, in any state):
- On i_wr_valid for stock s: ptr[s] becomes 0 if ptr[s] == i_buffer_size-1, otherwise ptr[s]+1.
- Also on that event: count[s] increments, saturating at i_buffer_size.

Address and width rules:
- oldest[s] = 0 if count[s] < i_buffer_size, otherwise ptr[s].
- Address = s*BUFFER_SIZE + idx, where idx wraps at i_buffer_size-1.
- Multiply by a constant; no intermediate truncation below the address width.
- Count width is $clog2(BUFFER_SIZE+1).

IDLE:
- i_rd_req is sampled here only. A request raised while busy is ignored, not queued.
- A request in cycle 0 snapshots count and oldest using registered values, i.e. before any same-cycle write.
- Snapshot count 0: o_empty_done pulses in cycle 1; stay in IDLE.
- Snapshot count n > 0: go to READ.

READ:
- o_rd_en is high in cycles 1..n.
- o_rd_addr steps from oldest to newest with wrap.
- After the n-th address, go to DRAIN.

DRAIN:
- One cycle, to receive the final RAM return; then go to IDLE.
- A new request is accepted from cycle n+2.

Output timing:
- o_sample_valid is o_rd_en delayed by one register, so high in cycles 2..n+1.
- o_sample_last is high in cycle n+1 only.
- o_busy is high in cycles 1..n+1.

Overrun:
- Writes continue updating the mirror during a burst; the burst uses its snapshot only.
- If a write to the burst stock arrives while its count is saturated, set a sticky flag.
- The flag is presented as o_overrun together with o_sample_last, then cleared.

Decomposition:
- Package volatility_pkg holds:
  - state enum {IDLE, READ, DRAIN};
  - localparams for address, count and index widths;
  - helper function stock_base(id) returning id*BUFFER_SIZE.
- Sub-module volatility_ptr_tracker holds the per-stock ptr/count table:
  - write update port;
  - one combinational lookup port returning count and oldest.

Test Plan:
- Empty read: after reset, req stock 2 -> o_empty_done in cycle 1; o_rd_en, o_sample_valid and o_busy stay 0.
- Partial fill: i_buffer_size=20; 3 writes to stock 1 with RAM preloaded 100,101,102 at addrs 20,21,22; then req -> addrs 20,21,22 in cycles 1-3; samples 100,101,102 in cycles 2-4; last in cycle 4.
- Wrap: i_buffer_size=5; 7 writes to stock 0 -> ptr=2, count=5; req -> addrs 2,3,4,0,1; last on the 5th sample; o_overrun=0.
- Overrun and busy req: same setup; write stock 0 and pulse req again in cycle 2 -> burst unchanged, o_overrun=1 with last, second req ignored; stock 3 unaffected.
- Simultaneous write/req: stock 3 holds 4 samples; write stock 3 and req stock 3 in the same cycle -> burst of 4 samples; next req returns 5.
- Reset mid-burst: i_reset in cycle 3 of a 10-sample burst -> next cycle all outputs 0, state IDLE; subsequent req -> o_empty_done.
